// File: rtl/msg_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// msg_uart_tx_pkg
//   Shared definitions for the message UART transmitter:
//   - controller FSM state encoding
//   - parity mode constants (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - frame_len(): number of bit slots in one UART frame
// ---------------------------------------------------------------------------
package msg_uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SEND = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Start bit + 8 data bits + optional parity + stop bits.
  function automatic int frame_len(input int parity, input int stop_bits);
    return 1 + 8 + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//   Serialises one byte per valid/ready handshake into an 8-bit UART frame:
//   start bit, data LSB-first, optional parity, STOP_BITS stop bits.
//
// Ports
//   clk    : clock
//   rst    : asynchronous active-high reset (line forced idle-high at once)
//   valid  : byte on data is offered; accepted when valid & ready
//   data   : byte to transmit
//   ready  : core can accept a byte (high while idle and in the last
//            cycle of the final stop bit)
//   tx     : serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_core
  import msg_uart_tx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 10416,
  parameter int PARITY         = PARITY_NONE,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int FRAME_BITS = frame_len(PARITY, STOP_BITS);
  localparam int CW         = $clog2(CYCLES_PER_BIT);

  localparam logic [CW-1:0] CYC_LAST    = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_PRELAST = CW'(CYCLES_PER_BIT - 2);
  localparam logic [3:0]    BIT_LAST    = 4'(FRAME_BITS - 1);

  logic          active;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic          par_bit;
  logic [11:0]   frame;
  logic          accept;

  assign ready  = ~active;
  assign accept = valid & ready;

  // Build the full frame image, LSB first on the wire. Bits above the real
  // frame length are ones, so unused slots simply look like more stop bits.
  always_comb begin
    par_bit = ^data;
    if (PARITY == PARITY_ODD) begin
      par_bit = ~par_bit;
    end
    frame = {3'b111, data, 1'b0};
    if (PARITY != PARITY_NONE) begin
      frame[9] = par_bit;
    end
  end

  // Bit timing and shifting. The busy flag drops one cycle before the final
  // stop bit ends, so a byte accepted in that last cycle starts its start bit
  // exactly on the bit boundary; the controller's one SEND cycle therefore
  // stretches the stop bit by a single cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      tx      <= 1'b1;
    end else if (accept) begin
      active  <= 1'b1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= frame[11:1];
      tx      <= frame[0];
    end else if (active) begin
      if (bit_cnt == BIT_LAST && cyc_cnt == CYC_PRELAST) begin
        active <= 1'b0;
      end
      if (cyc_cnt == CYC_LAST) begin
        cyc_cnt <= '0;
        bit_cnt <= bit_cnt + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[10:1]};
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/msg_uart_tx.sv
// ---------------------------------------------------------------------------
// msg_uart_tx
//   Sends a fixed message (MSG, char 0 in the low byte) over a UART line
//   when start rises. Optional looping (REPEAT) while start stays high, and
//   a level abort that ends the message after the frame in flight.
//
// Ports
//   clk      : clock (all logic in this domain)
//   rst      : asynchronous active-high reset
//   start    : rising edge launches a message (ignored while busy)
//   abort    : level; stop after the current frame, no done pulse
//   uart_tx  : serial line, idle high
//   busy     : high from launch until the controller is back in IDLE
//   done     : one-cycle pulse when a message completes normally
//   char_idx : index of the character currently being sent
// ---------------------------------------------------------------------------
module msg_uart_tx
  import msg_uart_tx_pkg::*;
#(
  parameter int                   CYCLES_PER_BIT = 10416,
  parameter int                   MSG_LEN        = 15,
  parameter logic [MSG_LEN*8-1:0] MSG            = "hitsz2024311278",
  parameter int                   PARITY         = 0,
  parameter int                   STOP_BITS      = 1,
  parameter int                   REPEAT         = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic                                                 abort,
  output logic                                                 uart_tx,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0]     char_idx
);

  localparam int               IDXW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(MSG_LEN - 1);

  state_t          state;
  state_t          state_n;
  logic [IDXW-1:0] idx_n;
  logic            start_q;
  logic            armed;
  logic            abort_q;
  logic            start_edge;
  logic            abort_seen;
  logic            core_valid;
  logic            core_ready;
  logic [7:0]      cur_char;

  // A start level that is already high when reset releases must not count
  // as an edge, so edges are only honoured once start has been seen low.
  assign start_edge = start & ~start_q & armed;
  assign abort_seen = abort_q | abort;
  assign core_valid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  // Combinational message ROM.
  assign cur_char = MSG[{char_idx, 3'b000} +: 8];

  // Next-state and next-index logic for the message controller.
  always_comb begin
    state_n = state;
    idx_n   = char_idx;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_n   = '0;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        if (core_ready) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_ready) begin
          if (abort_seen) begin
            state_n = ST_IDLE;
          end else if (char_idx != IDX_LAST) begin
            idx_n   = char_idx + IDXW'(1);
            state_n = ST_SEND;
          end else if (REPEAT != 0 && start) begin
            idx_n   = '0;
            state_n = ST_SEND;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Controller registers. The abort latch is cleared whenever the
  // controller is (re)entering IDLE, so an abort never leaks into the next
  // message, and abort while idle is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      char_idx <= '0;
      start_q  <= 1'b0;
      armed    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state    <= state_n;
      char_idx <= idx_n;
      start_q  <= start;
      if (!start) begin
        armed <= 1'b1;
      end
      if (state_n == ST_IDLE) begin
        abort_q <= 1'b0;
      end else if (abort && (state == ST_LOAD || state == ST_SEND || state == ST_WAIT)) begin
        abort_q <= 1'b1;
      end
    end
  end

  uart_tx_core #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT),
    .PARITY         (PARITY),
    .STOP_BITS      (STOP_BITS)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .valid (core_valid),
    .data  (cur_char),
    .ready (core_ready),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_msg_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_msg_uart_tx
//   Directed bench for msg_uart_tx with three instances sharing clk/rst:
//     dut_m : plain 8N1, message "abc"
//     dut_p : even parity, two stop bits
//     dut_r : REPEAT=1
//   The message "abc" is packed with char 0 in the low byte: 24'h636261.
// ---------------------------------------------------------------------------
module tb_msg_uart_tx;

  localparam int          CPB     = 4;
  localparam int          LEN     = 3;
  localparam logic [23:0] MSG_ABC = 24'h636261;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_m, abort_m, tx_m, busy_m, done_m;
  logic       start_p, abort_p, tx_p, busy_p, done_p;
  logic       start_r, abort_r, tx_r, busy_r, done_r;
  logic [1:0] idx_m, idx_p, idx_r;

  int checks   = 0;
  int failures = 0;
  int done_cnt_m = 0;
  int done_cnt_p = 0;
  int done_cnt_r = 0;

  msg_uart_tx #(.CYCLES_PER_BIT(CPB), .MSG_LEN(LEN), .MSG(MSG_ABC),
                .PARITY(0), .STOP_BITS(1), .REPEAT(0)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .abort(abort_m),
    .uart_tx(tx_m), .busy(busy_m), .done(done_m), .char_idx(idx_m));

  msg_uart_tx #(.CYCLES_PER_BIT(CPB), .MSG_LEN(LEN), .MSG(MSG_ABC),
                .PARITY(2), .STOP_BITS(2), .REPEAT(0)) dut_p (
    .clk(clk), .rst(rst), .start(start_p), .abort(abort_p),
    .uart_tx(tx_p), .busy(busy_p), .done(done_p), .char_idx(idx_p));

  msg_uart_tx #(.CYCLES_PER_BIT(CPB), .MSG_LEN(LEN), .MSG(MSG_ABC),
                .PARITY(0), .STOP_BITS(1), .REPEAT(1)) dut_r (
    .clk(clk), .rst(rst), .start(start_r), .abort(abort_r),
    .uart_tx(tx_r), .busy(busy_r), .done(done_r), .char_idx(idx_r));

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count every cycle in which done is high, so a stuck done shows up as
  // more than one pulse.
  always @(negedge clk) begin
    if (done_m === 1'b1) done_cnt_m++;
    if (done_p === 1'b1) done_cnt_p++;
    if (done_r === 1'b1) done_cnt_r++;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx_m;
      1:       return tx_p;
      default: return tx_r;
    endcase
  endfunction

  // Wait (bounded) until the selected line is low.
  task automatic wait_fall(input int sel, input int limit, output int waited, output bit timed_out);
    waited    = 0;
    timed_out = 1'b0;
    while (tx_of(sel) !== 1'b0) begin
      if (waited >= limit) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // Called at the first negedge where the start bit is visible; samples each
  // bit in its middle and returns at the middle of the last stop bit.
  task automatic recv_frame(input int sel, input int nstop, input bit has_par,
                            output logic [7:0] data, output logic par,
                            output logic start_ok, output logic stop_ok);
    repeat (CPB/2) @(negedge clk);
    start_ok = (tx_of(sel) === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      data[i] = tx_of(sel);
    end
    par = 1'b0;
    if (has_par) begin
      repeat (CPB) @(negedge clk);
      par = tx_of(sel);
    end
    stop_ok = 1'b1;
    for (int s = 0; s < nstop; s++) begin
      repeat (CPB) @(negedge clk);
      if (tx_of(sel) !== 1'b1) stop_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_m !== 1'b1)   begin failures++; $display("[TB] FAIL reset_tx: got %b want 1", tx_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy_m); end
    checks++; if (done_m !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done_m); end
    checks++; if (idx_m !== 2'd0)  begin failures++; $display("[TB] FAIL reset_idx: got %0d want 0", idx_m); end
    checks++; if (tx_p !== 1'b1 || busy_p !== 1'b0) begin failures++; $display("[TB] FAIL reset_par: tx %b busy %b want 1 0", tx_p, busy_p); end
    checks++; if (tx_r !== 1'b1 || busy_r !== 1'b0) begin failures++; $display("[TB] FAIL reset_rep: tx %b busy %b want 1 0", tx_r, busy_r); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: tx %b busy %b want 1 0", tx_m, busy_m); end
  endtask

  task automatic test_message();
    int lat, w, base;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    base    = done_cnt_m;
    start_m = 1'b1;
    lat     = 0;
    while (tx_m !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start_m = 1'b0;
    end
    checks++; if (lat != 3) begin failures++; $display("[TB] FAIL msg_latency: got %0d want 3", lat); end
    checks++; if (busy_m !== 1'b1) begin failures++; $display("[TB] FAIL msg_busy: got %b want 1", busy_m); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_fall(0, 20, w, to);
        checks++; if (w != 3) begin failures++; $display("[TB] FAIL msg_gap%0d: got %0d want 3", k, w); end
      end
      checks++; if (idx_m !== 2'(k)) begin failures++; $display("[TB] FAIL msg_idx%0d: got %0d want %0d", k, idx_m, k); end
      recv_frame(0, 1, 1'b0, d, p, s0, s1);
      checks++; if (d !== 8'h61 + 8'(k)) begin failures++; $display("[TB] FAIL msg_char%0d: got %h want %h", k, d, 8'h61 + 8'(k)); end
      checks++; if (s0 !== 1'b1 || s1 !== 1'b1) begin failures++; $display("[TB] FAIL msg_framing%0d: start %b stop %b want 1 1", k, s0, s1); end
    end
    w = 0;
    while (done_m !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++; if (w != 2) begin failures++; $display("[TB] FAIL msg_done_time: got %0d want 2", w); end
    checks++; if (busy_m !== 1'b1) begin failures++; $display("[TB] FAIL msg_busy_at_done: got %b want 1", busy_m); end
    @(negedge clk);
    checks++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin failures++; $display("[TB] FAIL msg_after_done: done %b busy %b want 0 0", done_m, busy_m); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt_m - base != 1) begin failures++; $display("[TB] FAIL msg_done_count: got %0d want 1", done_cnt_m - base); end
  endtask

  task automatic test_parity();
    int w, base;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    base    = done_cnt_p;
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    wait_fall(1, 20, w, to);
    checks++; if (w != 2) begin failures++; $display("[TB] FAIL par_latency: got %0d want 2", w); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_fall(1, 20, w, to);
        checks++; if (w != 3) begin failures++; $display("[TB] FAIL par_gap%0d: got %0d want 3", k, w); end
      end
      checks++; if (idx_p !== 2'(k)) begin failures++; $display("[TB] FAIL par_idx%0d: got %0d want %0d", k, idx_p, k); end
      recv_frame(1, 2, 1'b1, d, p, s0, s1);
      checks++; if (d !== 8'h61 + 8'(k)) begin failures++; $display("[TB] FAIL par_char%0d: got %h want %h", k, d, 8'h61 + 8'(k)); end
      checks++; if (p !== ((k == 2) ? 1'b0 : 1'b1)) begin failures++; $display("[TB] FAIL par_bit%0d: got %b want %b", k, p, (k == 2) ? 1'b0 : 1'b1); end
      checks++; if (s0 !== 1'b1 || s1 !== 1'b1) begin failures++; $display("[TB] FAIL par_framing%0d: start %b stop %b want 1 1", k, s0, s1); end
    end
    repeat (8) @(negedge clk);
    checks++; if (busy_p !== 1'b0) begin failures++; $display("[TB] FAIL par_busy_end: got %b want 0", busy_p); end
    checks++; if (done_cnt_p - base != 1) begin failures++; $display("[TB] FAIL par_done_count: got %0d want 1", done_cnt_p - base); end
  endtask

  task automatic test_abort();
    int w, base;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    base    = done_cnt_m;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_fall(0, 20, w, to);
    recv_frame(0, 1, 1'b0, d, p, s0, s1);
    checks++; if (d !== 8'h61) begin failures++; $display("[TB] FAIL abort_char0: got %h want 61", d); end
    wait_fall(0, 20, w, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL abort_char1_start: got timeout want frame"); end
    fork
      recv_frame(0, 1, 1'b0, d, p, s0, s1);
      begin
        repeat (CPB*3) @(negedge clk);
        abort_m = 1'b1;
        @(negedge clk);
        abort_m = 1'b0;
      end
    join
    checks++; if (d !== 8'h62 || s1 !== 1'b1) begin failures++; $display("[TB] FAIL abort_char1: got %h stop %b want 62 1", d, s1); end
    wait_fall(0, 60, w, to);
    checks++; if (!to) begin failures++; $display("[TB] FAIL abort_no_char2: got frame after %0d cycles want none", w); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b want 0", busy_m); end
    checks++; if (done_cnt_m - base != 0) begin failures++; $display("[TB] FAIL abort_done: got %0d want 0", done_cnt_m - base); end
  endtask

  task automatic test_back_to_back();
    int w, base;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    base    = done_cnt_m;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_fall(0, 20, w, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL b2b_start%0d: got timeout want frame", k); end
      fork
        recv_frame(0, 1, 1'b0, d, p, s0, s1);
        begin
          if (k == 0) begin
            repeat (10) @(negedge clk);
            start_m = 1'b1;
            @(negedge clk);
            start_m = 1'b0;
          end
        end
      join
      checks++; if (d !== 8'h61 + 8'(k)) begin failures++; $display("[TB] FAIL b2b_char%0d: got %h want %h", k, d, 8'h61 + 8'(k)); end
    end
    wait_fall(0, 100, w, to);
    checks++; if (!to) begin failures++; $display("[TB] FAIL b2b_extra_frame: got frame want none"); end
    checks++; if (done_cnt_m - base != 1 || busy_m !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done: count %0d busy %b want 1 0", done_cnt_m - base, busy_m); end
  endtask

  task automatic test_repeat();
    int w, base;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    base    = done_cnt_r;
    start_r = 1'b1;
    wait_fall(2, 20, w, to);
    checks++; if (w != 3) begin failures++; $display("[TB] FAIL rep_latency: got %0d want 3", w); end
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        wait_fall(2, 20, w, to);
        checks++; if (w != 3) begin failures++; $display("[TB] FAIL rep_gap%0d: got %0d want 3", k, w); end
      end
      checks++; if (idx_r !== 2'(k % 3)) begin failures++; $display("[TB] FAIL rep_idx%0d: got %0d want %0d", k, idx_r, k % 3); end
      if (k == 8) begin
        checks++; if (done_cnt_r - base != 0) begin failures++; $display("[TB] FAIL rep_early_done: got %0d want 0", done_cnt_r - base); end
      end
      recv_frame(2, 1, 1'b0, d, p, s0, s1);
      checks++; if (d !== 8'h61 + 8'(k % 3)) begin failures++; $display("[TB] FAIL rep_char%0d: got %h want %h", k, d, 8'h61 + 8'(k % 3)); end
      if (k == 7) start_r = 1'b0;
    end
    w = 0;
    while (done_r !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++; if (w != 2) begin failures++; $display("[TB] FAIL rep_done_time: got %0d want 2", w); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt_r - base != 1 || busy_r !== 1'b0) begin failures++; $display("[TB] FAIL rep_done: count %0d busy %b want 1 0", done_cnt_r - base, busy_r); end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    bit to;
    logic [7:0] d;
    logic p, s0, s1;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_fall(0, 20, w, to);
    recv_frame(0, 1, 1'b0, d, p, s0, s1);
    wait_fall(0, 20, w, to);
    repeat (CPB + CPB/2) @(negedge clk);
    checks++; if (tx_m !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_bit0: got %b want 0", tx_m); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_m !== 1'b1)   begin failures++; $display("[TB] FAIL rstmid_tx: got %b want 1", tx_m); end
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_flags: busy %b done %b want 0 0", busy_m, done_m); end
    checks++; if (idx_m !== 2'd0)  begin failures++; $display("[TB] FAIL rstmid_idx: got %0d want 0", idx_m); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_fall(0, 20, w, to);
    checks++; if (w != 2) begin failures++; $display("[TB] FAIL rstmid_restart_latency: got %0d want 2", w); end
    checks++; if (idx_m !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_restart_idx: got %0d want 0", idx_m); end
    recv_frame(0, 1, 1'b0, d, p, s0, s1);
    checks++; if (d !== 8'h61) begin failures++; $display("[TB] FAIL rstmid_restart_char: got %h want 61", d); end
    w = 0;
    while (busy_m !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_finish: busy %b want 0", busy_m); end
  endtask

  task automatic test_start_held();
    int hi, w;
    start_m = 1'b1;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_m !== 1'b0 || tx_m !== 1'b1) hi++;
    end
    checks++; if (hi != 0) begin failures++; $display("[TB] FAIL held_start_launch: active cycles %0d want 0", hi); end
    start_m = 1'b0;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    checks++; if (busy_m !== 1'b1) begin failures++; $display("[TB] FAIL held_start_relaunch: busy %b want 1", busy_m); end
    w = 0;
    while (busy_m !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("[TB] FAIL held_start_finish: busy %b want 0", busy_m); end
  endtask

  initial begin
    rst     = 1'b1;
    start_m = 1'b0; abort_m = 1'b0;
    start_p = 1'b0; abort_p = 1'b0;
    start_r = 1'b0; abort_r = 1'b0;
    test_reset();
    test_message();
    test_parity();
    test_abort();
    test_back_to_back();
    test_repeat();
    test_reset_mid_frame();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_uart_tx.md
MSG_UART_TX -- requirements
Module: msg_uart_tx

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 10416, is the number of clk cycles per UART bit; legal range is 2 or more.
REQ-002 Parameter MSG_LEN, default 15, is the number of characters in the message; legal range is 1 to 256.
REQ-003 Parameter MSG, default "hitsz2024311278", is the message packed as MSG_LEN*8 bits; char i = MSG[8*i +: 8], char 0 is sent first.
REQ-004 Parameter PARITY, default 0, selects the parity bit: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, is the number of stop bits; legal values are 1 and 2.
REQ-006 Parameter REPEAT, default 0; 1 makes the message loop while start is held high.
REQ-007 Port clk, input, 1 bit: the single clock (100 MHz); all logic is in this domain.
REQ-008 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 Port start, input, 1 bit: a rising edge launches a message.
REQ-010 Port abort, input, 1 bit: level; stops the message after the current frame.
REQ-011 Port uart_tx, output, 1 bit: serial line, idle high.
REQ-012 Port busy, output, 1 bit: high from launch until return to IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a message completes normally.
REQ-014 Port char_idx, output, IDXW = max(1, clog2(MSG_LEN)) bits: index of the character currently being sent.

Function
REQ-015 The start rising edge is detected by a registered copy of start (start=1 and start_q=0); start is synchronous to clk.
REQ-016 The controller FSM has states IDLE, LOAD, SEND, WAIT and DONE.
REQ-017 IDLE -> LOAD on a start edge; a start edge in any other state is ignored.
REQ-018 LOAD: clears char_idx to 0; next state is SEND.
REQ-019 SEND: asserts valid with MSG char char_idx to the core; the handshake completes on valid and ready in the same cycle; then go to WAIT.
REQ-020 WAIT: holds until the core reasserts ready, i.e. the frame is fully sent including its stop bits. Then:
  - abort seen during the frame -> IDLE, no done pulse;
  - char_idx < MSG_LEN-1 -> increment char_idx, go to SEND;
  - last char with REPEAT=0, or with REPEAT=1 and start=0 -> DONE;
  - last char with REPEAT=1 and start=1 -> char_idx wraps to 0, go to SEND.
REQ-021 DONE: pulses done for one cycle; next state is IDLE.
REQ-022 abort is latched when seen in LOAD, SEND or WAIT; the latch clears on entry to IDLE; abort in IDLE has no effect.
REQ-023 Frame format: start bit 0, then DATA bits LSB-first, then the parity bit (if enabled), then STOP_BITS ones; each bit lasts exactly CYCLES_PER_BIT cycles.
REQ-024 The parity bit is the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-025 Latency: uart_tx falls exactly 3 cycles after the cycle in which the start edge is sampled (LOAD, SEND, accept).
REQ-026 Back-to-back characters within a message have zero idle bit-time between frames, excluding a 1-cycle SEND gap (the stop bit is stretched by 1 cycle).
REQ-027 busy is high in LOAD, SEND, WAIT and DONE, and low only in IDLE.

Reset
REQ-028 While rst is high: uart_tx=1, busy=0, done=0, char_idx=0, FSM=IDLE, core idle with ready=1, abort latch=0, start_q=0.
REQ-029 rst asserted mid-frame forces uart_tx high immediately; it does not wait for a clock edge.
REQ-030 After rst deassertion, a start level that is already high does not launch a message until start falls and rises again.

Structure
REQ-031 A shared package holds the FSM state encoding, the PARITY_NONE/ODD/EVEN constants and the frame-length function (1+8+(PARITY!=0)+STOP_BITS).
REQ-032 One sub-module, uart_tx_core, contains the bit-timing counter, bit counter, shift register, parity generation and the valid/ready handshake.
REQ-033 The message ROM is combinational, indexed by char_idx from MSG.

Verification (CYCLES_PER_BIT=4, MSG_LEN=3, MSG="abc", parity none unless stated)
REQ-034 Start pulse -> uart_tx falls 3 cycles later; bytes 0x61, 0x62, 0x63 are sent LSB-first at 4 cycles/bit; done pulses once; busy falls the cycle after done.
REQ-035 PARITY=2, STOP_BITS=2, char 0x61 -> parity bit 1, then two stop bits; frame length 48 cycles.
REQ-036 abort asserted mid-char 1 -> char 1 completes, char 2 is never sent, no done, busy falls.
REQ-037 REPEAT=1 with start held high for 2.5 messages -> sequence a,b,c,a,b,c,a,b,c with char_idx wrapping 2->0; done occurs once, after the third "c".
REQ-038 rst pulsed during the data bits of char 1 -> uart_tx=1 in the same cycle; all outputs at reset values; a new start edge restarts from char 0.
REQ-039 A second start edge while busy -> ignored; exactly one message and one done.
